// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and constants for the on-chip memory line fetcher
//             (FSM state encoding, default FIFO depth, tied memory strobes).
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam int         c_fifo_depth_default = 4;
    localparam logic [3:0] c_byteenable         = 4'hF;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sync_fifo
//  Purpose  : Single-clock FIFO with synchronous flush. Push and pop in the
//             same cycle leave the occupancy unchanged. DEPTH must be a power
//             of two (pointers wrap naturally).
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_flush         - synchronous clear of all entries
//             i_push/i_push_data, i_pop/o_pop_data - write / read side
//             o_full, o_empty, o_count - status
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_sync_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = c_fifo_depth_default,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == (c_ptr_w+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Forcing zero when empty keeps the output deterministic without having
    // to reset the storage array.
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/onchip_mem_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_line_fetcher
//  Purpose  : Burst reader for one port of an on-chip RAM (read latency 1).
//             Reads word_count consecutive words from base_addr and streams
//             them out in address order on a valid/ready interface, never
//             issuing more reads than the output FIFO can absorb.
//  Ports    : clk, reset                 - clock, sync active-high reset
//             start, base_addr, word_count - burst request
//             abort                      - cancel burst (beats start)
//             busy, done                 - burst active / completion pulse
//             mem_*                      - memory port (read-only use)
//             out_data/out_valid/out_ready - output stream
//             stall_count                - only with FETCH_STALL_CNT_EN
//  Options  : define FETCH_STALL_CNT_EN to add the 16-bit saturating count
//             of back-pressure cycles during a burst.
//  Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_line_fetcher
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = c_fifo_depth_default,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam int             c_cnt_w = cnt_width(FIFO_DEPTH);
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w+1)'(FIFO_DEPTH);

    fetch_state_e        r_state;
    fetch_state_e        w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_remaining;
    logic                r_inflight;
    logic                r_done;

    logic                w_accept;
    logic                w_issue;
    logic                w_last_pop;
    logic                w_pop;
    logic                w_push;
    logic [c_cnt_w:0]    w_pending;
    logic [c_cnt_w-1:0]  w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    // ------------------------------------------------------------------
    // Output FIFO. An abort discards both stored words and the word that
    // is still on its way back from memory (flush beats the push).
    // ------------------------------------------------------------------
    fetch_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_flush     (abort),
        .i_push      (w_push),
        .i_push_data (mem_readdata),
        .i_pop       (w_pop),
        .o_pop_data  (out_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign out_valid = ~w_fifo_empty;
    assign w_pop     = out_valid & out_ready;
    // Read data is valid exactly one cycle after the address cycle.
    assign w_push    = r_inflight & ~w_fifo_full;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and read-issue decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_last_pop   = 1'b0;
        // Occupancy the FIFO will have when a read issued now returns:
        // current words, plus the read already in flight, minus this
        // cycle's pop. This lets a depth-2 FIFO still stream 1 word/cycle.
        w_pending    = {1'b0, w_fifo_count}
                     + (c_cnt_w+1)'(r_inflight)
                     - (c_cnt_w+1)'(w_pop);

        case (r_state)
            ST_IDLE: begin
                w_accept = start & ~abort;
                if (w_accept && (word_count != 16'd0)) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!abort && (w_pending < c_depth)) begin
                    w_issue = 1'b1;
                    if (r_remaining == 16'd1) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Last word is leaving the FIFO and nothing else is coming.
                if (!abort && !r_inflight && w_pop
                        && (w_fifo_count == c_cnt_w'(1))) begin
                    w_last_pop   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (abort) begin
            w_state_next = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers: address, words left to issue, in-flight flag,
    // completion pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            // A zero-length request completes immediately without any reads.
            r_done     <= (w_accept && (word_count == 16'd0)) || w_last_pop;

            if (w_accept && (word_count != 16'd0)) begin
                r_addr      <= base_addr;
                r_remaining <= word_count;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - 16'd1;
            end
        end
    end

    assign busy           = (r_state != ST_IDLE);
    assign done           = r_done;
    assign mem_address    = r_addr;
    assign mem_chipselect = w_issue;
    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign mem_byteenable = c_byteenable;

`ifdef FETCH_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Back-pressure counter: cycles a word was waiting but not taken.
    // ------------------------------------------------------------------
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_accept) begin
            r_stall_count <= '0;
        end else if (busy && out_valid && !out_ready
                     && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_line_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_onchip_mem_line_fetcher
//  Purpose  : Self-checking bench for onchip_mem_line_fetcher. A small memory
//             model answers reads one cycle late; a burst-level reference
//             model (expected address/data queues) is checked every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_line_fetcher;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    onchip_mem_line_fetcher #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- counters and check helper ----------------
    int vectors = 0;
    int fails   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- memory model (latency 1) ----------------
    function automatic logic [31:0] word_at(input logic [15:0] a);
        return {~a, a};
    endfunction

    logic        r_rd_valid = 1'b0;
    logic [15:0] r_rd_addr  = '0;
    always @(posedge clk) begin
        r_rd_valid <= mem_chipselect;
        r_rd_addr  <= mem_address;
    end
    assign mem_readdata = r_rd_valid ? word_at(r_rd_addr) : 32'hDEAD_BEEF;

    // ---------------- reference model state and logs ----------------
    bit          m_active = 0;
    int          m_total = 0, m_issued = 0, m_consumed = 0;
    logic [15:0] m_addr_q[$];
    logic [15:0] m_data_q[$];
    bit          m_done_next = 0;
    bit          m_prev_stall = 0;
    logic [31:0] m_prev_data = '0;
    logic [15:0] m_prev_addr = '0;
    bit          m_addr_may_move = 1;
    logic [15:0] m_stall = '0;

    logic [15:0] log_addr[$];
    int          log_cs_cyc[$];
    logic [31:0] log_data[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          cyc_no = 0;

    always @(negedge clk) begin
        bit accepted;
        bit act_now;
        cyc_no++;
        accepted = 0;
        act_now  = m_active;
        if (reset) begin
            m_active = 0;
            m_addr_q.delete();
            m_data_q.delete();
            m_issued = 0;
            m_consumed = 0;
            m_total = 0;
            m_done_next = 0;
            m_prev_stall = 0;
            m_addr_may_move = 1;
            m_stall = '0;
        end else begin
            chk("done", done, m_done_next);
            chk("busy", busy, m_active);
            chk("tied_strobes", {mem_clken, mem_write, mem_byteenable}, 6'b10_1111);
            if (!m_addr_may_move) chk("addr_track", mem_address, m_prev_addr);
            if (m_prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, m_prev_data);
            end
            if (mem_chipselect) begin
                log_addr.push_back(mem_address);
                log_cs_cyc.push_back(cyc_no);
                if (m_addr_q.size() == 0) begin
                    chk("spurious_read", mem_chipselect, 1'b0);
                end else begin
                    chk("mem_address", mem_address, m_addr_q.pop_front());
                    m_data_q.push_back(mem_address);
                    m_issued++;
                end
            end
            if (out_valid && out_ready) begin
                log_data.push_back(out_data);
                if (m_data_q.size() == 0) begin
                    chk("spurious_word", out_valid, 1'b0);
                end else begin
                    chk("out_data", out_data, word_at(m_data_q.pop_front()));
                    m_consumed++;
                end
            end
            chk("outstanding_le_depth", (m_issued - m_consumed) <= DEPTH, 1'b1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc_no;
            end
`ifdef FETCH_STALL_CNT_EN
            chk("stall_count", stall_count, m_stall);
`endif
            // advance the model to the next cycle
            m_done_next = 0;
            if (abort) begin
                m_active = 0;
                m_addr_q.delete();
                m_data_q.delete();
                m_issued = 0;
                m_consumed = 0;
            end else if (m_active && m_consumed == m_total) begin
                m_active = 0;
                m_done_next = 1;
            end else if (!m_active && start) begin
                accepted = 1;
                if (word_count == 16'd0) begin
                    m_done_next = 1;
                end else begin
                    m_active = 1;
                    m_total = word_count;
                    m_issued = 0;
                    m_consumed = 0;
                    m_addr_q.delete();
                    m_data_q.delete();
                    for (int k = 0; k < int'(word_count); k++)
                        m_addr_q.push_back(base_addr + 16'(k));
                end
            end
            if (accepted) m_stall = '0;
            else if (act_now && out_valid && !out_ready && m_stall != 16'hFFFF) m_stall++;
            m_prev_stall    = out_valid && !out_ready && !abort;
            m_prev_data     = out_data;
            m_prev_addr     = mem_chipselect ? mem_address + 16'd1 : mem_address;
            m_addr_may_move = accepted && (word_count != 16'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] n);
        start = 1'b1; base_addr = b; word_count = n;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) cyc(1);
        chk("idle_timeout", busy, 1'b0);
        cyc(2);
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_cs_cyc.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = '0; word_count = '0;
        cyc(3);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_cs", mem_chipselect, 1'b0);
        chk("reset_addr", mem_address, 16'h0000);
        chk("reset_out_data", out_data, 32'h0);
        reset = 1'b0;
        cyc(2);

        // base 0x0100, 8 words, full throughput
        clear_logs();
        do_start(16'h0100, 16'd8);
        wait_idle(40);
        chk("t1_reads", log_addr.size(), 8);
        chk("t1_first_addr", log_addr[0], 16'h0100);
        chk("t1_last_addr", log_addr[7], 16'h0107);
        chk("t1_consecutive", log_cs_cyc[7] - log_cs_cyc[0], 7);
        chk("t1_words", log_data.size(), 8);
        chk("t1_first_word", log_data[0], 32'hFEFF_0100);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_latency", done_cyc - log_cs_cyc[0], 10);

        // address wrap
        clear_logs();
        do_start(16'hFFFE, 16'd4);
        wait_idle(40);
        chk("t2_a0", log_addr[0], 16'hFFFE);
        chk("t2_a1", log_addr[1], 16'hFFFF);
        chk("t2_a2", log_addr[2], 16'h0000);
        chk("t2_a3", log_addr[3], 16'h0001);
        chk("t2_done_cnt", done_cnt, 1);

        // back-pressure: 16 words, ready low for 10 cycles
        clear_logs();
        out_ready = 1'b0;
        do_start(16'h0300, 16'd16);
        cyc(9);
        chk("t3_reads_capped", log_addr.size(), DEPTH);
        chk("t3_valid_held", out_valid, 1'b1);
        out_ready = 1'b1;
        wait_idle(80);
        chk("t3_words", log_data.size(), 16);
        chk("t3_last_word", log_data[15], 32'hFCF0_030F);
        chk("t3_done_cnt", done_cnt, 1);

        // abort after 3 words of 10, then a clean burst
        clear_logs();
        do_start(16'h0400, 16'd10);
        for (int i = 0; i < 30 && log_data.size() < 3; i++) cyc(1);
        chk("t4_three_words", log_data.size() >= 3, 1'b1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("t4_busy_after_abort", busy, 1'b0);
        chk("t4_valid_after_abort", out_valid, 1'b0);
        cyc(3);
        chk("t4_no_done", done_cnt, 0);
        clear_logs();
        do_start(16'h0500, 16'd3);
        wait_idle(40);
        chk("t4_restart_addr", log_addr[0], 16'h0500);
        chk("t4_restart_words", log_data.size(), 3);
        chk("t4_restart_word0", log_data[0], 32'hFAFF_0500);
        chk("t4_restart_done", done_cnt, 1);

        // zero-length request, then start while busy
        clear_logs();
        do_start(16'h0600, 16'd0);
        cyc(3);
        chk("t5_no_reads", log_addr.size(), 0);
        chk("t5_done_once", done_cnt, 1);
        chk("t5_not_busy", busy, 1'b0);
        clear_logs();
        do_start(16'h0700, 16'd5);
        start = 1'b1; base_addr = 16'h0800; word_count = 16'd9;
        cyc(1);
        start = 1'b0;
        wait_idle(40);
        chk("t5_reads", log_addr.size(), 5);
        chk("t5_last_addr", log_addr[4], 16'h0704);
        chk("t5_done_cnt", done_cnt, 1);

`ifdef FETCH_STALL_CNT_EN
        // stall counter: data waiting for 5 cycles
        clear_logs();
        out_ready = 1'b0;
        do_start(16'h0900, 16'd4);
        for (int i = 0; i < 10 && !out_valid; i++) cyc(1);
        cyc(5);
        out_ready = 1'b1;
        wait_idle(40);
        chk("t6_stall_count", stall_count, 16'd5);
        chk("t6_words", log_data.size(), 4);
`endif

        // reset in the middle of a burst
        clear_logs();
        do_start(16'h0A00, 16'd8);
        cyc(4);
        reset = 1'b1;
        cyc(1);
        chk("t7_busy", busy, 1'b0);
        chk("t7_done", done, 1'b0);
        chk("t7_out_valid", out_valid, 1'b0);
        chk("t7_addr", mem_address, 16'h0000);
        chk("t7_out_data", out_data, 32'h0);
        reset = 1'b0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
